// File: rtl/ddr2_cmd_arbiter_pkg.sv
// Shared definitions for the DDR2 command arbiter: command encodings,
// FSM state encoding and default bus widths.
package ddr2_cmd_arbiter_pkg;

  localparam int ADDR_BITS_DEF = 14;
  localparam int BA_BITS_DEF   = 3;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_LM   = 4'b0000;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_NOP  = 4'b0111;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

endpackage

// File: rtl/ddr2_cmd_arbiter_if.sv
// Requester and DRAM-pin bundle around the command arbiter; the arbiter
// sits on the slave side, requesters and pins on the master side.
interface ddr2_cmd_arbiter_if
  import ddr2_cmd_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int BA_BITS   = BA_BITS_DEF
);

  logic                 init_end;
  logic                 init_cke;
  logic [3:0]           init_cmd;
  logic [BA_BITS-1:0]   init_ba;
  logic [ADDR_BITS-1:0] init_addr;

  logic                 aref_end;
  logic [3:0]           aref_cmd;
  logic [BA_BITS-1:0]   aref_ba;
  logic [ADDR_BITS-1:0] aref_addr;

  logic                 wr_req;
  logic                 wr_end;
  logic [3:0]           wr_cmd;
  logic [BA_BITS-1:0]   wr_ba;
  logic [ADDR_BITS-1:0] wr_addr;

  logic                 rd_req;
  logic                 rd_end;
  logic [3:0]           rd_cmd;
  logic [BA_BITS-1:0]   rd_ba;
  logic [ADDR_BITS-1:0] rd_addr;

  logic                 aref_req;
  logic                 aref_en;
  logic                 wr_en;
  logic                 rd_en;
  logic                 ddr_cke;
  logic [3:0]           ddr_cmd;
  logic [BA_BITS-1:0]   ddr_ba;
  logic [ADDR_BITS-1:0] ddr_addr;
  logic                 ref_overrun;

  modport slave (
    input  init_end, init_cke, init_cmd, init_ba, init_addr,
    input  aref_end, aref_cmd, aref_ba, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
    input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    output aref_req, aref_en, wr_en, rd_en,
    output ddr_cke, ddr_cmd, ddr_ba, ddr_addr, ref_overrun
  );

  modport master (
    output init_end, init_cke, init_cmd, init_ba, init_addr,
    output aref_end, aref_cmd, aref_ba, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
    output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    input  aref_req, aref_en, wr_en, rd_en,
    input  ddr_cke, ddr_cmd, ddr_ba, ddr_addr, ref_overrun
  );

endinterface

// File: rtl/ddr2_aref_timer.sv
// Periodic auto-refresh request generator with a sticky overrun flag for
// a refresh period that expires before the previous refresh was granted.
module ddr2_aref_timer
  import ddr2_cmd_arbiter_pkg::*;
#(
  parameter int REF_INTERVAL = 3120
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_aref_req,
  output logic o_ref_overrun
);

  localparam int CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_aref_req;
  logic             r_overrun;
  logic             w_wrap;

  assign w_wrap = i_en && (r_cnt == CNT_W'(REF_INTERVAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_aref_req <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (!i_en || w_wrap) r_cnt <= '0;
      else                 r_cnt <= r_cnt + 1'b1;
      // A new period outranks the grant-side clear arriving in the same cycle.
      if (w_wrap)     r_aref_req <= 1'b1;
      else if (i_clr) r_aref_req <= 1'b0;
      if (w_wrap && r_aref_req && !i_clr) r_overrun <= 1'b1;
    end
  end

  assign o_aref_req    = r_aref_req;
  assign o_ref_overrun = r_overrun;

endmodule

// File: rtl/ddr2_cmd_arbiter.sv
// DDR2 command-bus owner: init passthrough, then fixed-priority grant of
// refresh / write / read with all pin outputs registered.
module ddr2_cmd_arbiter
  import ddr2_cmd_arbiter_pkg::*;
#(
  parameter int ADDR_BITS    = ADDR_BITS_DEF,
  parameter int BA_BITS      = BA_BITS_DEF,
  parameter int REF_INTERVAL = 3120
) (
  input logic              clk,
  input logic              rst_n,
  ddr2_cmd_arbiter_if.slave bus
);

  state_t               r_state, w_state_next;
  logic                 r_cke, w_cke_next;
  logic [3:0]           r_cmd, w_cmd_next;
  logic [BA_BITS-1:0]   r_ba, w_ba_next;
  logic [ADDR_BITS-1:0] r_addr, w_addr_next;
  logic                 r_aref_en, w_aref_en_next;
  logic                 r_wr_en, w_wr_en_next;
  logic                 r_rd_en, w_rd_en_next;
  logic                 w_aref_req;
  logic                 w_ref_overrun;

  ddr2_aref_timer #(.REF_INTERVAL(REF_INTERVAL)) u_aref_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (r_state != S_INIT),
    .i_clr        (r_aref_en),
    .o_aref_req   (w_aref_req),
    .o_ref_overrun(w_ref_overrun)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_INIT;
      r_cke     <= 1'b0;
      r_cmd     <= CMD_NOP;
      r_ba      <= '0;
      r_addr    <= '0;
      r_aref_en <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cke     <= w_cke_next;
      r_cmd     <= w_cmd_next;
      r_ba      <= w_ba_next;
      r_addr    <= w_addr_next;
      r_aref_en <= w_aref_en_next;
      r_wr_en   <= w_wr_en_next;
      r_rd_en   <= w_rd_en_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_INIT:  if (bus.init_end) w_state_next = S_IDLE;
      S_IDLE: begin
        if (w_aref_req)      w_state_next = S_AREF;
        else if (bus.wr_req) w_state_next = S_WRITE;
        else if (bus.rd_req) w_state_next = S_READ;
      end
      S_AREF:  if (bus.aref_end) w_state_next = S_IDLE;
      S_WRITE: if (bus.wr_end)   w_state_next = S_IDLE;
      S_READ:  if (bus.rd_end)   w_state_next = S_IDLE;
      default: w_state_next = S_INIT;
    endcase
  end

  always_comb begin
    w_cke_next  = 1'b1;
    w_cmd_next  = CMD_NOP;
    w_ba_next   = '0;
    w_addr_next = '0;
    case (r_state)
      S_INIT: begin
        w_cke_next  = bus.init_cke;
        w_cmd_next  = bus.init_cmd;
        w_ba_next   = bus.init_ba;
        w_addr_next = bus.init_addr;
      end
      S_AREF: begin
        w_cmd_next  = bus.aref_cmd;
        w_ba_next   = bus.aref_ba;
        w_addr_next = bus.aref_addr;
      end
      S_WRITE: begin
        w_cmd_next  = bus.wr_cmd;
        w_ba_next   = bus.wr_ba;
        w_addr_next = bus.wr_addr;
      end
      S_READ: begin
        w_cmd_next  = bus.rd_cmd;
        w_ba_next   = bus.rd_ba;
        w_addr_next = bus.rd_addr;
      end
      default: ;
    endcase
    // Grants fire only on the IDLE exit, so each pulse marks a state's first cycle.
    w_aref_en_next = (r_state == S_IDLE) && (w_state_next == S_AREF);
    w_wr_en_next   = (r_state == S_IDLE) && (w_state_next == S_WRITE);
    w_rd_en_next   = (r_state == S_IDLE) && (w_state_next == S_READ);
  end

  assign bus.aref_req    = w_aref_req;
  assign bus.aref_en     = r_aref_en;
  assign bus.wr_en       = r_wr_en;
  assign bus.rd_en       = r_rd_en;
  assign bus.ddr_cke     = r_cke;
  assign bus.ddr_cmd     = r_cmd;
  assign bus.ddr_ba      = r_ba;
  assign bus.ddr_addr    = r_addr;
  assign bus.ref_overrun = w_ref_overrun;

endmodule

// File: doc/ddr2_cmd_arbiter.md
Name: ddr2_cmd_arbiter

Overview:
Central command scheduler for the DDR2 controller. After power-up it passes the init sequencer's CKE/command/bank/address straight to the DRAM pins. Once init_end is seen it owns the DDR2 command bus, generating periodic auto-refresh requests and granting the bus to exactly one of refresh, write or read. The selected requester's command is registered onto the pins.

Parameters:
ADDR_BITS, 14, DRAM address bus width
BA_BITS, 3, bank address width
REF_INTERVAL, 3120, clk cycles between refresh requests (tREFI/tCK)

Ports:
clk  in  1  controller clock
rst_n  in  1  asynchronous active-low reset
init_end  in  1  init sequence complete (level, stays high)
init_cke  in  1  CKE from init sequencer
init_cmd / init_ba / init_addr  in  4 / BA_BITS / ADDR_BITS  init command, bank, address
aref_end  in  1  refresh module finished (1-cycle pulse)
aref_cmd / aref_ba / aref_addr  in  4 / BA_BITS / ADDR_BITS  refresh command source
wr_req  in  1  write requester wants bus (level)
wr_end  in  1  write module finished (pulse)
wr_cmd / wr_ba / wr_addr  in  4 / BA_BITS / ADDR_BITS  write command source
rd_req  in  1  read requester wants bus (level)
rd_end  in  1  read module finished (pulse)
rd_cmd / rd_ba / rd_addr  in  4 / BA_BITS / ADDR_BITS  read command source
aref_req  out  1  refresh pending; wr/rd modules must close bursts early while high
aref_en / wr_en / rd_en  out  1 each  grant pulses
ddr_cke  out  1  DRAM CKE
ddr_cmd  out  4  {cs_n,ras_n,cas_n,we_n}
ddr_ba  out  BA_BITS  DRAM bank address
ddr_addr  out  ADDR_BITS  DRAM address
ref_overrun  out  1  sticky: a refresh period expired while the previous refresh was still pending

Behaviour:
- Reset values: state=S_INIT, ddr_cke=0, ddr_cmd=NOP (4'b0111), ddr_ba=0, ddr_addr=0, all grants=0, aref_req=0, ref_overrun=0, ref_cnt=0.
- States:
  - S_INIT -> S_IDLE when init_end=1.
  - S_IDLE: fixed priority aref_req > wr_req > rd_req. Moves to S_AREF, S_WRITE or S_READ respectively; stays in S_IDLE if none is requesting.
  - S_AREF -> S_IDLE on aref_end. S_WRITE -> S_IDLE on wr_end. S_READ -> S_IDLE on rd_end.
- Grants:
  - The matching *_en is registered and high for exactly the first cycle of the granted state.
  - At least one S_IDLE cycle always separates two grants.
  - An *_end is honoured only in its own state and ignored otherwise. An *_end in the same cycle as its *_en is honoured, giving a 1-cycle grant.
  - No preemption: a refresh arriving mid-write waits for wr_end.
- Output mux:
  - All ddr_* outputs are registered, one cycle of latency. A source command presented in cycle n appears on the pins in cycle n+1.
  - S_INIT: init_* passed through, and ddr_cke follows init_cke delayed by one cycle.
  - Every other state: ddr_cke=1.
  - S_IDLE drives NOP with ba=0 and addr=0.
  - S_AREF, S_WRITE and S_READ drive the aref_*, wr_* and rd_* sources respectively.
- Refresh timer:
  - ref_cnt is held at 0 until the FSM leaves S_INIT. After that it counts 0..REF_INTERVAL-1 and wraps.
  - On wrap it sets aref_req. aref_req is cleared in the cycle aref_en=1.
  - Wrap and clear in the same cycle: set wins, so aref_req stays 1 and no overrun is flagged.
  - Wrap while aref_req=1 with no clear in that cycle sets ref_overrun=1 until reset.
- Reset mid-operation: everything returns to reset values immediately, including the init handoff. The FSM waits for init_end again.
- Input hygiene: req levels sampled only in S_IDLE; init_* ignored after S_INIT.

Decomposition:
- Shared define file holds:
  - command encodings: NOP 4'b0111, PRE 4'b0010, AREF 4'b0001, LM 4'b0000, plus ACT, RD, WR;
  - state encodings;
  - ADDR_BITS and BA_BITS defaults.
- One sub-module, ddr2_aref_timer, holds ref_cnt, aref_req and ref_overrun. It takes an enable input from the FSM and a clear input from aref_en.
- The FSM and output mux stay in ddr2_cmd_arbiter.

Test Plan:
1. Init passthrough (REF_INTERVAL=64): drive init_cmd=PRE with init_addr[10]=1 and init_cke=1 before init_end -> ddr_cmd=PRE and ddr_addr=14'h0400 one cycle later, ddr_cke=1. Raise init_end -> state S_IDLE and ddr_cmd=NOP next cycle.
2. Periodic refresh: after init, with no other requests -> aref_req rises exactly 64 cycles after leaving S_INIT, aref_en pulses the following cycle, aref_cmd=AREF is forwarded. aref_end returns to S_IDLE and aref_req=0.
3. Priority: in the same S_IDLE cycle assert wr_req, rd_req and aref_req -> aref_en first; after aref_end, one idle cycle, then wr_en; after wr_end, one idle cycle, then rd_en.
4. No preemption: grant a write, hold wr_end low for 100 cycles with REF_INTERVAL=64 -> aref_req=1 throughout, no aref_en until wr_end, and ref_overrun stays 0 when aref_en clears the request before the second wrap.
5. Overrun: hold the write for 130 cycles -> second wrap with aref_req still 1 sets ref_overrun=1, which stays set after the refresh completes.
6. Reset mid-read: assert rst_n=0 during S_READ -> ddr_cmd=NOP, ddr_cke=0, grants 0 and ref_overrun 0 asynchronously. After release the block waits in S_INIT until init_end.
